// File: rtl/nwc_stream_driver.sv
// Host-side driver for nwc_processor: loads paired coefficient words from a valid/ready stream,
// starts the job, captures the uninterruptible result burst into a RAM buffer and replays it
// as a backpressurable stream. Optional watchdog is enabled by defining NWC_DRV_TIMEOUT_EN.
module nwc_stream_driver #(
  parameter int unsigned N_WORDS        = 2048,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [59:0] s_data_a,
  input  logic [59:0] s_data_b,
  output logic [59:0] nwc_data_in0,
  output logic [59:0] nwc_data_in1,
  output logic        nwc_write_enable,
  output logic        nwc_start,
  input  logic        nwc_ready,
  input  logic [59:0] nwc_data_out,
  input  logic        nwc_output_active,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [59:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_WORDS - 1);
  localparam logic [ADDR_W:0]   LastIdx  = (ADDR_W + 1)'(N_WORDS - 1);

  typedef enum logic [2:0] {StFlush, StLoad, StArm, StWaitOut, StCapture, StDrain} state_e;

  state_e state;
  // Tracks the processor's unresettable write address, so it must survive rst.
  logic [ADDR_W-1:0] wr_cnt = '0;
  logic [ADDR_W:0]   cap_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [59:0]       mem [N_WORDS];
  logic [59:0]       rd_data;
  logic              rd_pend, rd_last;
  logic              sk_valid, sk_last;
  logic [59:0]       sk_data;
  logic              cap_we, rd_issue, pop;
  logic [1:0]        avail;

  assign cap_we = nwc_output_active && (state == StWaitOut || state == StCapture);
  assign pop    = m_valid && m_ready;
  // Words held in the head, the skid, or in flight from the RAM.
  assign avail  = 2'(m_valid) + 2'(sk_valid) + 2'(rd_pend);
  // Reading the word being captured this very cycle is allowed; the RAM read bypasses it.
  assign rd_issue = ((rd_cnt < cap_cnt) || (cap_we && rd_cnt == cap_cnt)) &&
                    (avail <= 2'd1 + 2'(pop));

`ifdef NWC_DRV_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Control FSM: load, arm, wait for burst, capture, drain; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= (wr_cnt != '0) ? StFlush : StLoad;
      s_ready          <= 1'b0;
      nwc_write_enable <= 1'b0;
      nwc_start        <= 1'b0;
      nwc_data_in0     <= '0;
      nwc_data_in1     <= '0;
      busy             <= 1'b1;
      cap_cnt          <= '0;
`ifdef NWC_DRV_TIMEOUT_EN
      timeout_err      <= 1'b0;
      tmo_cnt          <= '0;
`endif
    end else begin
      nwc_write_enable <= 1'b0;
      nwc_start        <= 1'b0;
      unique case (state)
        StFlush: begin
          nwc_write_enable <= 1'b1;
          nwc_data_in0     <= '0;
          nwc_data_in1     <= '0;
          wr_cnt           <= wr_cnt + 1'b1;
          if (wr_cnt == LastAddr) begin
            state   <= StLoad;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        StLoad: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (s_valid && s_ready) begin
            nwc_data_in0     <= s_data_a;
            nwc_data_in1     <= s_data_b;
            nwc_write_enable <= 1'b1;
            wr_cnt           <= wr_cnt + 1'b1;
            if (wr_cnt == LastAddr) begin
              state   <= StArm;
              s_ready <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        StArm: begin
          if (nwc_ready) begin
            nwc_start <= 1'b1;
            state     <= StWaitOut;
`ifdef NWC_DRV_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        StWaitOut: begin
          if (cap_we) begin
            state   <= StCapture;
            cap_cnt <= (ADDR_W + 1)'(1);
          end
`ifdef NWC_DRV_TIMEOUT_EN
          else if (tmo_cnt == TmoLast) begin
            timeout_err <= 1'b1;
            state       <= StLoad;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end
        StCapture: begin
          if (cap_we) begin
            cap_cnt <= cap_cnt + 1'b1;
            if (cap_cnt == LastIdx) state <= StDrain;
          end
        end
        StDrain: begin
          if (pop && m_last) begin
            state   <= StLoad;
            cap_cnt <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

  // Result buffer: capture write port plus registered read with write-through bypass.
  always_ff @(posedge clk) begin
    if (cap_we) mem[cap_cnt[ADDR_W-1:0]] <= nwc_data_out;
    if (rd_issue) begin
      rd_data <= (cap_we && cap_cnt[ADDR_W-1:0] == rd_cnt[ADDR_W-1:0]) ? nwc_data_out
                                                                      : mem[rd_cnt[ADDR_W-1:0]];
    end
  end

  // Output stream: head register plus one-entry skid fed by the RAM read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt   <= '0;
      rd_pend  <= 1'b0;
      rd_last  <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      sk_valid <= 1'b0;
      sk_last  <= 1'b0;
      sk_data  <= '0;
    end else begin
      rd_pend <= rd_issue;
      rd_last <= rd_issue && (rd_cnt == LastIdx);
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      else if (pop && m_last) rd_cnt <= '0;
      if (!m_valid || m_ready) begin
        if (sk_valid) begin
          m_valid  <= 1'b1;
          m_data   <= sk_data;
          m_last   <= sk_last;
          sk_valid <= rd_pend;
          sk_data  <= rd_data;
          sk_last  <= rd_last;
        end else begin
          m_valid <= rd_pend;
          m_data  <= rd_data;
          m_last  <= rd_last;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_nwc_stream_driver.sv
// Directed bench for nwc_stream_driver with a behavioural nwc_processor (monomial multiply).
module tb_nwc_stream_driver;
  localparam int N   = 2048;
  localparam int NC  = 2 * N;
  localparam int LAT = 16;
  localparam logic [29:0] Q = 30'd1073479681;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_ready;
  logic [59:0] s_data_a = '0, s_data_b = '0;
  logic [59:0] nwc_data_in0, nwc_data_in1;
  logic nwc_write_enable, nwc_start, nwc_ready;
  logic [59:0] nwc_data_out = '0;
  logic nwc_output_active = 1'b0;
  logic m_valid, m_ready = 1'b0, m_last, busy, timeout_err;
  logic [59:0] m_data;

  always #5 clk = ~clk;

  nwc_stream_driver #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_a(s_data_a), .s_data_b(s_data_b),
    .nwc_data_in0(nwc_data_in0), .nwc_data_in1(nwc_data_in1),
    .nwc_write_enable(nwc_write_enable), .nwc_start(nwc_start), .nwc_ready(nwc_ready),
    .nwc_data_out(nwc_data_out), .nwc_output_active(nwc_output_active),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- processor model ----------------
  logic [59:0] pa [N];
  logic [59:0] pb [N];
  logic [59:0] res [N];
  logic [10:0] paddr = '0;
  int  we_count = 0, nz_count = 0, start_count = 0, bad_start = 0;
  int  lat_cnt = 0, out_idx = 0;
  bit  wait_out = 0, bursting = 0;
  logic pbusy = 1'b0;
  bit  hold_ready = 0, no_output = 0;

  assign nwc_ready = !pbusy && !hold_ready;

  // A is assumed to be a monomial a*x^k; wrapped terms are negated (negacyclic).
  function automatic void compute_product();
    logic [29:0] a [NC];
    logic [29:0] b [NC];
    logic [29:0] av;
    longint unsigned p;
    int k, s;
    av = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      a[2*i] = pa[i][29:0]; a[2*i+1] = pa[i][59:30];
      b[2*i] = pb[i][29:0]; b[2*i+1] = pb[i][59:30];
    end
    for (int i = NC - 1; i >= 0; i--) if (a[i] != '0) begin k = i; av = a[i]; end
    for (int j = 0; j < NC; j += 2) begin
      logic [29:0] r [2];
      for (int h = 0; h < 2; h++) begin
        s = j + h - k;
        if (s >= 0) p = (64'(av) * 64'(b[s])) % 64'(Q);
        else begin
          p = (64'(av) * 64'(b[s + NC])) % 64'(Q);
          p = (p == 0) ? 64'd0 : 64'(Q) - p;
        end
        r[h] = p[29:0];
      end
      res[j/2] = {r[1], r[0]};
    end
  endfunction

  always @(posedge clk) begin
    if (nwc_write_enable) begin
      pa[paddr] = nwc_data_in0;
      pb[paddr] = nwc_data_in1;
      if (nwc_data_in0 != '0 || nwc_data_in1 != '0) nz_count++;
      paddr = paddr + 11'd1;
      we_count++;
    end
    if (nwc_start) begin
      start_count++;
      if (!nwc_ready) bad_start++;
      compute_product();
      if (!no_output) begin pbusy <= 1'b1; lat_cnt = LAT; wait_out = 1; end
    end else if (wait_out) begin
      if (lat_cnt == 0) begin wait_out = 0; out_idx = 0; bursting = 1; end
      else lat_cnt--;
    end
    if (bursting) begin
      if (out_idx < N) begin
        nwc_output_active <= 1'b1;
        nwc_data_out      <= res[out_idx];
        out_idx++;
      end else begin
        bursting = 0;
        nwc_output_active <= 1'b0;
        nwc_data_out      <= '0;
        pbusy             <= 1'b0;
      end
    end
  end

  // ---------------- stimulus data ----------------
  logic [59:0] src_a [N];
  logic [59:0] src_b [N];
  logic [59:0] exp_w [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A = 1 (x^0), B random with coefficients below Q: product equals B.
  task automatic fill_identity();
    for (int i = 0; i < N; i++) begin
      src_a[i] = (i == 0) ? 60'h1 : 60'h0;
      src_b[i] = {1'b0, 29'($urandom), 1'b0, 29'($urandom)};
      exp_w[i] = src_b[i];
    end
  endtask

  // A = B = x^1 (coeff[1] sits in the high half of word 0): product is x^2 = word 1 low half.
  task automatic fill_shift1();
    for (int i = 0; i < N; i++) begin
      src_a[i] = (i == 0) ? {30'd1, 30'd0} : 60'h0;
      src_b[i] = src_a[i];
      exp_w[i] = (i == 1) ? 60'h1 : 60'h0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the final handshake edge.
  task automatic load_words(input int count, input bit gaps);
    int i = 0;
    int cyc = 0;
    while (i < count && cyc < 4 * N + 100) begin
      s_valid  = gaps ? ((cyc % 2) == 0) : 1'b1;
      s_data_a = src_a[i];
      s_data_b = src_b[i];
      if (s_valid && s_ready) i++;
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("load_handshakes", 64'(i), 64'(count));
  endtask

  task automatic collect(input bit throttle, input string tag);
    int idx = 0;
    int cyc = 0;
    bit stall = 0;
    logic [59:0] held = '0;
    while (idx < N && cyc < 8 * N) begin
      if (stall) begin
        chk({tag, "_stall_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_stall_data"}, 64'(m_data), 64'(held));
      end
      m_ready = throttle ? ((cyc % 3) == 0) : 1'b1;
      if (m_valid && m_ready) begin
        chk({tag, "_data"}, 64'(m_data), 64'(exp_w[idx]));
        chk({tag, "_last"}, 64'(m_last), 64'(idx == N - 1));
        if (idx == 0 || idx == N - 1) chk({tag, "_s_ready_low"}, 64'(s_ready), 64'd0);
        idx++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      cyc++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk({tag, "_word_count"}, 64'(idx), 64'(N));
    chk({tag, "_no_extra"}, 64'(m_valid), 64'd0);
    chk({tag, "_back_to_load"}, 64'(s_ready), 64'd1);
    chk({tag, "_not_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_job(input bit gaps, input bit throttle, input bit hold, input string tag);
    int we0 = we_count;
    int st0 = start_count;
    hold_ready = hold;
    load_words(N, gaps);
    @(negedge clk);
    chk({tag, "_writes"}, 64'(we_count - we0), 64'(N));
    if (hold) begin
      repeat (10) @(negedge clk);
      chk({tag, "_no_start_unready"}, 64'(start_count - st0), 64'd0);
      chk({tag, "_arm_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_arm_busy"}, 64'(busy), 64'd1);
      hold_ready = 0;
    end
    collect(throttle, tag);
    chk({tag, "_starts"}, 64'(start_count - st0), 64'd1);
    chk({tag, "_start_when_ready"}, 64'(bad_start), 64'd0);
    chk({tag, "_timeout_clear"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    int we0, nz0, cyc;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_write_enable", 64'(nwc_write_enable), 64'd0);
    chk("rst_start", 64'(nwc_start), 64'd0);
    chk("rst_data_in0", 64'(nwc_data_in0), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_no_flush", 64'(we_count), 64'd0);

    fill_identity();
    run_job(1'b0, 1'b0, 1'b0, "t1");
    fill_identity();
    run_job(1'b0, 1'b1, 1'b0, "t2");
    fill_identity();
    run_job(1'b1, 1'b0, 1'b1, "t3");

    // Abort mid-load: FLUSH must complete the remaining zero writes.
    for (int i = 0; i < N; i++) begin
      src_a[i] = {29'($urandom), 1'b1, 30'($urandom)};
      src_b[i] = 60'($urandom);
    end
    we0 = we_count;
    nz0 = nz_count;
    load_words(700, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t4_partial_writes", 64'(we_count - we0), 64'd700);
    @(negedge clk);
    chk("t4_flush_s_ready", 64'(s_ready), 64'd0);
    chk("t4_flush_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 3000) begin @(negedge clk); cyc++; end
    @(negedge clk);
    chk("t4_total_writes", 64'(we_count - we0), 64'd2048);
    chk("t4_flush_zero", 64'(nz_count - nz0), 64'd700);
    chk("t4_addr_aligned", 64'(paddr), 64'd0);
    chk("t4_load_s_ready", 64'(s_ready), 64'd1);
    fill_shift1();
    run_job(1'b0, 1'b0, 1'b0, "t4");

    fill_identity();
    run_job(1'b0, 1'b0, 1'b0, "t5a");
    fill_identity();
    run_job(1'b0, 1'b0, 1'b0, "t5b");

`ifdef NWC_DRV_TIMEOUT_EN
    no_output = 1;
    fill_identity();
    load_words(N, 1'b0);
    cyc = 0;
    while (!nwc_start && cyc < 50) begin @(negedge clk); cyc++; end
    chk("t6_start_seen", 64'(nwc_start), 64'd1);
    repeat (99) @(negedge clk);
    chk("t6_before_timeout", 64'(timeout_err), 64'd0);
    @(negedge clk);
    chk("t6_timeout", 64'(timeout_err), 64'd1);
    chk("t6_s_ready", 64'(s_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
